// File: rtl/unidade_controle_pkg.sv
//============================================================================
// Module : unidade_controle_pkg
// Brief  : Opcodes, register-field sizes, FSM time-step encoding and opcode
//          classification helpers shared by the multicycle control unit.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package unidade_controle_pkg;

  // Register file size and the width of the Rx/Ry selector fields
  localparam int NREG   = 8;
  localparam int REG_AW = 3;

  // Instruction opcodes (IR[W-1:W-4])
  localparam logic [3:0] OP_MV  = 4'b0000;
  localparam logic [3:0] OP_MVI = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_OR  = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;

  // ALU opcode driven whenever the ALU result is not being captured
  localparam logic [3:0] ALU_IDLE = 4'b0000;

  // Time steps of the multicycle sequence
  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  // True for the opcodes that run the three-step A/G/writeback sequence
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_OR) ||
           (op == OP_SLT) || (op == OP_SLL) || (op == OP_SRL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/unidade_controle_dec3to8.sv
//============================================================================
// Module : dec3to8
// Brief  : 3-bit binary to 8-bit one-hot decoder used for register selects.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module dec3to8 (
  input  logic [2:0] sel,
  output logic [7:0] onehot
);

  // Exactly one output bit set, at the position named by sel
  always_comb begin
    onehot = 8'd0;
    onehot[sel] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/unidade_controle.sv
//============================================================================
// Module : unidade_controle
// Brief  : Multicycle control FSM for the processor datapath. Latches the
//          instruction word, steps T0..T3 and drives register selects, bus
//          source, A/G loads, ALU opcode and the Done pulse.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module unidade_controle
  import unidade_controle_pkg::*;
#(
  parameter int W = 16
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Run,
  input  logic [W-1:0]    DIN,
  output logic            IRin,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            DINout,
  output logic            Gout,
  output logic            Ain,
  output logic            Gin,
  output logic [3:0]      AluOp,
  output logic            Done
);

  state_t       state;
  state_t       state_next;
  logic [W-1:0] ir;

  logic [3:0]        op;
  logic [REG_AW-1:0] rx;
  logic [REG_AW-1:0] ry;
  logic [NREG-1:0]   rx_sel;
  logic [NREG-1:0]   ry_sel;

  // Low instruction bits carry no meaning for this instruction set
  logic unused_ir_low;
  assign unused_ir_low = ^ir[W-11:0];

  assign op = ir[W-1:W-4];
  assign rx = ir[W-5:W-7];
  assign ry = ir[W-8:W-10];

  dec3to8 u_dec_rx (.sel(rx), .onehot(rx_sel));
  dec3to8 u_dec_ry (.sel(ry), .onehot(ry_sel));

  // Time-step register and instruction register; IR only loads on a T0 start
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (state == T0 && Run) begin
        ir <= DIN;
      end
    end
  end

  // Next-step and control-strobe decode from the current step and opcode
  always_comb begin
    state_next = state;
    IRin       = 1'b0;
    Rin        = '0;
    Rout       = '0;
    DINout     = 1'b0;
    Gout       = 1'b0;
    Ain        = 1'b0;
    Gin        = 1'b0;
    AluOp      = ALU_IDLE;
    Done       = 1'b0;

    unique case (state)
      T0: begin
        // Reset forces T0; masking here keeps every output low while it is held
        IRin = Run & ~Reset;
        if (Run) begin
          state_next = T1;
        end
      end

      T1: begin
        if (op == OP_MV) begin
          Rout       = ry_sel;
          Rin        = rx_sel;
          Done       = 1'b1;
          state_next = T0;
        end else if (op == OP_MVI) begin
          DINout     = 1'b1;
          Rin        = rx_sel;
          Done       = 1'b1;
          state_next = T0;
        end else if (is_alu_op(op)) begin
          Rout       = rx_sel;
          Ain        = 1'b1;
          state_next = T2;
        end else begin
          // Unknown opcode: complete without touching any register
          Done       = 1'b1;
          state_next = T0;
        end
      end

      T2: begin
        Rout       = ry_sel;
        Gin        = 1'b1;
        AluOp      = op;
        state_next = T3;
      end

      T3: begin
        Gout       = 1'b1;
        Rin        = rx_sel;
        Done       = 1'b1;
        state_next = T0;
      end

      default: begin
        state_next = T0;
      end
    endcase
  end

endmodule

`default_nettype wire
